// File: rtl/reset_sequencer.sv
// Staged reset controller: synchronizes board reset release, then frees
// each downstream stage in order; soft requests replay the same sequence.
module reset_sequencer #(
    parameter int NSTG = 3,
    parameter int NREQ = 2,
    parameter int HOLD = 16,
    parameter int GAP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] soft_req,
    output logic [NREQ-1:0] soft_ack,
    output logic [NSTG-1:0] rst_out,
    output logic            done,
    output logic            cause
);

    localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NSTG) + 1;

    typedef enum logic [1:0] {
        S_SYNC,
        S_HOLD,
        S_REL,
        S_RUN
    } state_t;

    state_t          state;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [NREQ-1:0] pick;

    // Lowest-index requester wins.
    always_comb begin
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (soft_req[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            state    <= S_SYNC;
            cnt      <= '0;
            idx      <= '0;
            rst_out  <= '1;
            done     <= 1'b0;
            soft_ack <= '0;
            cause    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], 1'b1};
            soft_ack <= '0;
            unique case (state)
                S_SYNC: begin
                    // Start on the edge where the second flop first reads 1.
                    if (sync_q[0] && !sync_q[1]) begin
                        state <= S_HOLD;
                        cnt   <= '0;
                    end
                end
                S_HOLD: begin
                    if (cnt == CW'(HOLD - 1)) begin
                        rst_out[0] <= 1'b0;
                        cnt        <= '0;
                        if (NSTG == 1) begin
                            done  <= 1'b1;
                            state <= S_RUN;
                        end else begin
                            idx   <= IW'(1);
                            state <= S_REL;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_REL: begin
                    if (cnt == CW'(GAP - 1)) begin
                        rst_out[idx] <= 1'b0;
                        cnt          <= '0;
                        if (idx == IW'(NSTG - 1)) begin
                            done  <= 1'b1;
                            state <= S_RUN;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (|soft_req) begin
                        soft_ack <= pick;
                        rst_out  <= '1;
                        done     <= 1'b0;
                        cause    <= 1'b1;
                        cnt      <= '0;
                        idx      <= '0;
                        state    <= S_HOLD;
                    end
                end
                default: state <= S_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: release times derived from the start edge of
// each sequence, plus a NSTG=1/HOLD=1/GAP=1 corner instance.
module tb_reset_sequencer;

    localparam int NS = 3;
    localparam int HL = 16;
    localparam int GP = 4;

    logic       clk;
    logic       rst;
    logic [1:0] soft_req;
    logic [1:0] soft_ack;
    logic [2:0] rst_out;
    logic       done;
    logic       cause;

    logic       rst1;
    logic [0:0] req1;
    logic [0:0] ack1;
    logic [0:0] ro1;
    logic       done1;
    logic       cause1;

    int checks;
    int failures;

    // Model: edges since release, start edge of current sequence.
    int         e;
    int         t0;
    logic       mcause;
    logic [1:0] pend;
    logic [1:0] mack;

    reset_sequencer #(
        .NSTG(NS), .NREQ(2), .HOLD(HL), .GAP(GP)
    ) u_dut (
        .clk(clk), .rst(rst), .soft_req(soft_req),
        .soft_ack(soft_ack), .rst_out(rst_out),
        .done(done), .cause(cause)
    );

    reset_sequencer #(
        .NSTG(1), .NREQ(1), .HOLD(1), .GAP(1)
    ) u_c (
        .clk(clk), .rst(rst1), .soft_req(req1),
        .soft_ack(ack1), .rst_out(ro1),
        .done(done1), .cause(cause1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] exp_rst(int n, int s);
        logic [2:0] r;
        for (int k = 0; k < NS; k++)
            r[k] = !(n >= s + HL + k * GP);
        return r;
    endfunction

    function automatic bit exp_done(int n, int s);
        return n >= s + HL + (NS - 1) * GP;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s e=%0d obs=%0h exp=%0h", tag, e, obs, exp);
        end
    endtask

    task automatic check_all();
        if (rst) begin
            check("rst_out_r", 32'(rst_out), 32'h7);
            check("done_r", 32'(done), 32'h0);
            check("cause_r", 32'(cause), 32'h0);
            check("ack_r", 32'(soft_ack), 32'h0);
        end else begin
            check("rst_out", 32'(rst_out), 32'(exp_rst(e, t0)));
            check("done", 32'(done), 32'(exp_done(e, t0)));
            check("cause", 32'(cause), 32'(mcause));
            check("ack", 32'(soft_ack), 32'(mack));
        end
    endtask

    task automatic step();
        soft_req = pend;
        @(posedge clk);
        if (!rst) begin
            e++;
            mack = 2'b00;
            if (exp_done(e - 1, t0) && pend != 2'b00) begin
                mack   = pend[0] ? 2'b01 : 2'b10;
                pend   = pend & ~mack;
                t0     = e;
                mcause = 1'b1;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic do_rst(input int n);
        rst = 1'b1;
        #1;
        e      = 0;
        t0     = 2;
        mcause = 1'b0;
        mack   = 2'b00;
        check_all();
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rst1     = 1'b1;
        req1     = 1'b0;
        soft_req = 2'b00;
        pend     = 2'b00;
        e        = 0;
        t0       = 2;
        mcause   = 1'b0;
        mack     = 2'b00;

        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;

        // Power-on, then single, then simultaneous soft requests.
        repeat (30) step();
        pend = 2'b01;
        repeat (30) step();
        pend = 2'b11;
        repeat (8) step();
        repeat (60) step();
        pend = 2'b10;
        repeat (3) step();
        repeat (40) step();

        // Hardware reset right after bit 0 is freed.
        do_rst(2);
        repeat (19) step();
        do_rst(1);
        repeat (30) step();

        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3)
                pend = pend | 2'($urandom_range(1, 3));
            else if (r == 3 && $urandom_range(0, 3) == 0)
                do_rst(int'($urandom_range(1, 3)));
            step();
        end
        pend = 2'b00;
        repeat (30) step();

        // Corner instance: NSTG=1, HOLD=1, GAP=1.
        rst1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("c_e1_ro", 32'(ro1), 32'h1);
        check("c_e1_done", 32'(done1), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("c_e2_ro", 32'(ro1), 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("c_e3_ro", 32'(ro1), 32'h0);
        check("c_e3_done", 32'(done1), 32'h1);
        check("c_e3_cause", 32'(cause1), 32'h0);
        req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("c_s_ack", 32'(ack1), 32'h1);
        check("c_s_ro", 32'(ro1), 32'h1);
        check("c_s_done", 32'(done1), 32'h0);
        check("c_s_cause", 32'(cause1), 32'h1);
        req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("c_s1_ro", 32'(ro1), 32'h0);
        check("c_s1_done", 32'(done1), 32'h1);
        check("c_s1_ack", 32'(ack1), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
